// File: rtl/apb_gen2_pkg.sv
// Shared types and constants for the generation-2 APB master:
// FSM state encoding, default parameter values and slave-index width.
package apb_gen2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int unsigned DEF_ADDR_W      = 8;
  localparam int unsigned DEF_DATA_W      = 8;
  localparam int unsigned DEF_NUM_SLAVES  = 4;
  localparam int unsigned DEF_TIMEOUT_CYC = 255;

  // Slave-index width: clog2 of the fan-out, never below one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_gen2_decode.sv
// Combinational slave decode: index to one-hot select, range check,
// and selection of the addressed slave's pready/prdata/pslverr.
module apb_gen2_decode
  import apb_gen2_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned SEL_W      = sel_w(NUM_SLAVES)
) (
  input  logic [SEL_W-1:0]             idx,
  input  logic [NUM_SLAVES-1:0]        pready,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]        pslverr,
  output logic [NUM_SLAVES-1:0]        sel_oh_c,
  output logic                         in_range_c,
  output logic                         pready_c,
  output logic [DATA_W-1:0]            prdata_c,
  output logic                         pslverr_c
);

  localparam int unsigned CMP_W = SEL_W + 1;

  always_comb begin : decode_mux
    sel_oh_c   = '0;
    pready_c   = 1'b0;
    prdata_c   = '0;
    pslverr_c  = 1'b0;
    in_range_c = ({1'b0, idx} < CMP_W'(NUM_SLAVES));
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (idx == SEL_W'(i)) begin
        sel_oh_c[i] = 1'b1;
        pready_c    = pready[i];
        prdata_c    = prdata[i*DATA_W +: DATA_W];
        pslverr_c   = pslverr[i];
      end
    end
  end

endmodule

// File: rtl/apb_master_gen2.sv
// Single-outstanding APB master: accepts a command, runs SETUP/ACCESS on the
// addressed slave and reports a one-cycle response. Optional access-timeout
// watchdog enabled by defining APB_MASTER_GEN2_TIMEOUT_EN.
module apb_master_gen2
  import apb_gen2_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned NUM_SLAVES  = DEF_NUM_SLAVES,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                         pclk,
  input  logic                         prst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  input  logic [DATA_W/8-1:0]          req_strb,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [NUM_SLAVES-1:0]        psel,
  output logic                         penable,
  output logic                         pwrite,
  output logic [ADDR_W-1:0]            paddr,
  output logic [DATA_W-1:0]            pwdata,
  output logic [DATA_W/8-1:0]          pstrb,
  input  logic [NUM_SLAVES-1:0]        pready,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]        pslverr
);

  localparam int unsigned SEL_W  = sel_w(NUM_SLAVES);
  localparam int unsigned STRB_W = DATA_W / 8;

  state_t state, state_d;

  logic [SEL_W-1:0]      idx_c;
  logic [NUM_SLAVES-1:0] sel_oh_c;
  logic                  in_range_c;
  logic                  pready_c;
  logic [DATA_W-1:0]     prdata_c;
  logic                  pslverr_c;
  logic                  accept_c;
  logic                  timeout_c;

  logic                  req_ready_d, rsp_valid_d, rsp_err_d, penable_d, pwrite_d;
  logic [DATA_W-1:0]     rsp_rdata_d, pwdata_d;
  logic [NUM_SLAVES-1:0] psel_d;
  logic [ADDR_W-1:0]     paddr_d;
  logic [STRB_W-1:0]     pstrb_d;

  // In IDLE decode the incoming command; otherwise the captured address.
  assign idx_c    = (state == IDLE) ? req_addr[ADDR_W-1 -: SEL_W] : paddr[ADDR_W-1 -: SEL_W];
  assign accept_c = (state == IDLE) && req_valid && req_ready;

  apb_gen2_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .DATA_W     (DATA_W),
    .SEL_W      (SEL_W)
  ) u_decode (
    .idx        (idx_c),
    .pready     (pready),
    .prdata     (prdata),
    .pslverr    (pslverr),
    .sel_oh_c   (sel_oh_c),
    .in_range_c (in_range_c),
    .pready_c   (pready_c),
    .prdata_c   (prdata_c),
    .pslverr_c  (pslverr_c)
  );

`ifdef APB_MASTER_GEN2_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  logic [TO_W-1:0] to_cnt;

  // Counts stalled ACCESS cycles; idle at zero outside ACCESS.
  always_ff @(posedge pclk) begin
    if (prst || state != ACCESS) begin
      to_cnt <= '0;
    end else if (!pready_c) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign timeout_c = (state == ACCESS) && !pready_c && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge pclk) begin
    if (prst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept_c) state_d = in_range_c ? SETUP : RESP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready_c || timeout_c) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    req_ready_d = (state_d == IDLE);
    penable_d   = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);
    psel_d      = (state_d == SETUP || state_d == ACCESS) ? sel_oh_c : '0;
    paddr_d     = paddr;
    pwrite_d    = pwrite;
    pwdata_d    = pwdata;
    pstrb_d     = pstrb;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;

    if (accept_c && in_range_c) begin
      paddr_d  = req_addr;
      pwrite_d = req_write;
      pstrb_d  = req_write ? req_strb : '0;
      if (req_write) pwdata_d = req_wdata;
    end

    if (accept_c && !in_range_c) begin
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b1;
    end

    if (state == ACCESS && pready_c) begin
      rsp_rdata_d = pwrite ? '0 : prdata_c;
      rsp_err_d   = pslverr_c;
    end else if (timeout_c) begin
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge pclk) begin
    if (prst) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
    end else begin
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      psel      <= psel_d;
      penable   <= penable_d;
      pwrite    <= pwrite_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
      pstrb     <= pstrb_d;
    end
  end

endmodule

// File: tb/tb_apb_master_gen2.sv
// Directed self-checking bench for apb_master_gen2 (4-slave and 3-slave builds).
module tb_apb_master_gen2;

  logic pclk = 1'b0;
  logic prst;
  always #5 pclk = ~pclk;

  // 4-slave instance
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr, req_wdata;
  logic [0:0]  req_strb;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;
  logic [3:0]  psel;
  logic        penable, pwrite;
  logic [7:0]  paddr, pwdata;
  logic [0:0]  pstrb;
  logic [3:0]  pready, pslverr;
  logic [31:0] prdata;

  // 3-slave instance
  logic        req_valid3, req_ready3, req_write3;
  logic [7:0]  req_addr3, req_wdata3;
  logic [0:0]  req_strb3;
  logic        rsp_valid3, rsp_err3;
  logic [7:0]  rsp_rdata3;
  logic [2:0]  psel3;
  logic        penable3, pwrite3;
  logic [7:0]  paddr3, pwdata3;
  logic [0:0]  pstrb3;
  logic [2:0]  pready3, pslverr3;
  logic [23:0] prdata3;

  apb_master_gen2 #(
    .ADDR_W(8), .DATA_W(8), .NUM_SLAVES(4), .TIMEOUT_CYC(4)
  ) u_dut (
    .pclk(pclk), .prst(prst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  apb_master_gen2 #(
    .ADDR_W(8), .DATA_W(8), .NUM_SLAVES(3), .TIMEOUT_CYC(4)
  ) u_dut3 (
    .pclk(pclk), .prst(prst),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_write(req_write3),
    .req_addr(req_addr3), .req_wdata(req_wdata3), .req_strb(req_strb3),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
    .psel(psel3), .penable(penable3), .pwrite(pwrite3), .paddr(paddr3),
    .pwdata(pwdata3), .pstrb(pstrb3),
    .pready(pready3), .prdata(prdata3), .pslverr(pslverr3)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Presents one command for a single edge; returns in cycle 1 (SETUP).
  task automatic send(input logic wr, input logic [7:0] a, input logic [7:0] d, input logic s);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_strb  = s;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    prst = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_strb = 0;
    pready = 0; pslverr = 0; prdata = 0;
    req_valid3 = 0; req_write3 = 0; req_addr3 = 0; req_wdata3 = 0; req_strb3 = 0;
    pready3 = 0; pslverr3 = 0; prdata3 = 24'h665544;

    // Reset values
    step(); step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_paddr", paddr, 0);
    prst = 1'b0;
    step();
    chk("post_rst_req_ready", req_ready, 1);

    // Write to slave 1; pready[1] already high in SETUP (must be ignored)
    pready = 4'b0010;
    send(1'b1, 8'h45, 8'hA5, 1'b1);
    chk("wr_setup_psel", psel, 4'b0010);
    chk("wr_setup_penable", penable, 0);
    chk("wr_setup_paddr", paddr, 8'h45);
    chk("wr_setup_pwrite", pwrite, 1);
    chk("wr_setup_pwdata", pwdata, 8'hA5);
    chk("wr_setup_pstrb", pstrb, 1);
    chk("wr_setup_req_ready", req_ready, 0);
    step();
    chk("wr_access_psel", psel, 4'b0010);
    chk("wr_access_penable", penable, 1);
    step();
    chk("wr_resp_valid", rsp_valid, 1);
    chk("wr_resp_err", rsp_err, 0);
    chk("wr_resp_psel", psel, 0);
    chk("wr_resp_penable", penable, 0);
    step();
    chk("wr_idle_valid", rsp_valid, 0);
    chk("wr_idle_req_ready", req_ready, 1);
    chk("wr_idle_paddr_hold", paddr, 8'h45);

    // Read from slave 3 with three wait states
    pready = 4'b0000;
    prdata = {8'h5A, 8'h11, 8'h22, 8'h77};
    send(1'b0, 8'hC3, 8'h99, 1'b1);
    chk("rd_setup_psel", psel, 4'b1000);
    chk("rd_setup_pstrb", pstrb, 0);
    chk("rd_setup_pwdata_hold", pwdata, 8'hA5);
    chk("rd_setup_pwrite", pwrite, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rd_wait_paddr", paddr, 8'hC3);
      chk("rd_wait_penable", penable, 1);
      chk("rd_wait_psel", psel, 4'b1000);
    end
    step();
    chk("rd_acc4_penable", penable, 1);
    pready = 4'b1000;
    step();
    chk("rd_resp_valid", rsp_valid, 1);
    chk("rd_resp_rdata", rsp_rdata, 8'h5A);
    chk("rd_resp_err", rsp_err, 0);
    pready = 4'b0000;
    step();
    chk("rd_idle_rdata_hold", rsp_rdata, 8'h5A);

    // Slave-2 error with slave-0 pready toggling and pslverr[0] stuck high
    pready  = 4'b0001;
    pslverr = 4'b0001;
    prdata  = {8'h5A, 8'h33, 8'h22, 8'hEE};
    send(1'b0, 8'h80, 8'h00, 1'b0);
    chk("se_setup_psel", psel, 4'b0100);
    pready[0] = ~pready[0];
    step();
    chk("se_acc1_penable", penable, 1);
    pready[0] = ~pready[0];
    step();
    chk("se_acc2_penable", penable, 1);
    chk("se_acc2_valid", rsp_valid, 0);
    pready[0] = ~pready[0];
    pready[2] = 1'b1;
    pslverr[2] = 1'b1;
    step();
    chk("se_resp_valid", rsp_valid, 1);
    chk("se_resp_err", rsp_err, 1);
    chk("se_resp_rdata", rsp_rdata, 8'h33);
    pready = 0; pslverr = 0;
    step();
    chk("se_idle_err_hold", rsp_err, 1);

    // Reset during ACCESS aborts the transfer
    send(1'b1, 8'h10, 8'h3C, 1'b1);
    step();
    chk("rst_mid_penable_pre", penable, 1);
    prst = 1'b1;
    step();
    chk("rst_mid_psel", psel, 0);
    chk("rst_mid_penable", penable, 0);
    chk("rst_mid_valid", rsp_valid, 0);
    chk("rst_mid_paddr", paddr, 0);
    chk("rst_mid_req_ready", req_ready, 0);
    prst = 1'b0;
    step();
    chk("rst_mid_rel_valid", rsp_valid, 0);
    chk("rst_mid_rel_req_ready", req_ready, 1);

`ifdef APB_MASTER_GEN2_TIMEOUT_EN
    // Stalled slave: RESP after four ACCESS cycles, then normal operation
    pready = 0;
    send(1'b0, 8'h45, 8'h00, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("to_access_penable", penable, 1);
    end
    step();
    chk("to_resp_valid", rsp_valid, 1);
    chk("to_resp_err", rsp_err, 1);
    chk("to_resp_rdata", rsp_rdata, 0);
    chk("to_resp_psel", psel, 0);
    step();
    chk("to_idle_req_ready", req_ready, 1);
    pready = 4'b0001;
    send(1'b1, 8'h05, 8'h12, 1'b1);
    step(); step();
    chk("to_next_valid", rsp_valid, 1);
    chk("to_next_err", rsp_err, 0);
    pready = 0;
    step();
`endif

    // Decode error on the 3-slave build
    chk("de_req_ready", req_ready3, 1);
    req_valid3 = 1'b1;
    req_addr3  = 8'hC0;
    step();
    req_valid3 = 1'b0;
    chk("de_resp_valid", rsp_valid3, 1);
    chk("de_resp_err", rsp_err3, 1);
    chk("de_resp_rdata", rsp_rdata3, 0);
    chk("de_psel", psel3, 0);
    chk("de_penable", penable3, 0);
    step();
    chk("de_idle_valid", rsp_valid3, 0);
    chk("de_idle_req_ready", req_ready3, 1);
    chk("de_idle_psel", psel3, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
